// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command issuer: op codes, word width,
// FSM state encoding and the push byte-count helper.
package calc_pkg;

    localparam int CALC_WORD = 32;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] MUL  = 3'd2;
    localparam logic [2:0] DIV  = 3'd3;
    localparam logic [2:0] MOD  = 3'd4;
    localparam logic [2:0] POP  = 3'd5;
    localparam logic [2:0] DUP  = 3'd6;
    localparam logic [2:0] SWAP = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } calc_state_t;

    // Fewest bytes whose upper zeros can be dropped; negatives always need 4.
    function automatic logic [2:0] byte_count(input logic [CALC_WORD-1:0] v);
        if (v[31:8] == 24'h0)
            return 3'd1;
        else if (v[31:16] == 16'h0)
            return 3'd2;
        else if (v[31:24] == 8'h0)
            return 3'd3;
        else
            return 3'd4;
    endfunction

endpackage

// File: rtl/calc_command_issuer.sv
// Turns push/op requests into paced one-cycle calculator command strobes,
// checking the calculator error bit after every command.
module calc_command_issuer
    import calc_pkg::*;
#(
    parameter int CMD_GAP = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_push,
    input  logic [CALC_WORD-1:0] req_value,
    input  logic [2:0]           req_op,
    output logic                 push_num,
    output logic                 shift_and_push,
    output logic                 do_other_op,
    output logic [7:0]           input_number,
    output logic [2:0]           other_op_code,
    input  logic                 calc_error_bit,
    input  logic [CALC_WORD-1:0] calc_out_num,
    output logic                 busy,
    output logic                 done,
    output logic                 resp_error,
    output logic [CALC_WORD-1:0] resp_out_num
);

    calc_state_t          state_reg, state_next;
    logic                 is_push_reg;
    logic                 first_reg;
    logic [CALC_WORD-1:0] shift_reg;
    logic [2:0]           op_reg;
    logic [1:0]           rem_reg;
    logic [7:0]           gap_cnt_reg;
    logic                 err_reg;
    logic                 resp_error_reg;
    logic [CALC_WORD-1:0] resp_out_num_reg;

    logic                 accept;
    logic                 last_cmd;
    logic [2:0]           req_bytes;
    logic [CALC_WORD-1:0] req_aligned;

    assign accept   = req_valid & req_ready;
    assign last_cmd = calc_error_bit | (rem_reg == 2'd0);

    // Left-align the significant bytes so the next byte is always [31:24].
    always_comb begin
        req_bytes   = byte_count(req_value);
        req_aligned = req_value;
        case (req_bytes)
            3'd1:    req_aligned = {req_value[7:0], 24'h0};
            3'd2:    req_aligned = {req_value[15:0], 16'h0};
            3'd3:    req_aligned = {req_value[23:0], 8'h0};
            default: req_aligned = req_value;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        push_num       = 1'b0;
        shift_and_push = 1'b0;
        do_other_op    = 1'b0;
        done           = 1'b0;
        busy           = (state_reg != IDLE);
        req_ready      = (state_reg == IDLE) & ~reset;
        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready)
                    state_next = ISSUE;
            end
            ISSUE: begin
                push_num       = is_push_reg & first_reg;
                shift_and_push = is_push_reg & ~first_reg;
                do_other_op    = ~is_push_reg;
                state_next     = WAIT;
            end
            WAIT: begin
                if (gap_cnt_reg == 8'd0)
                    state_next = CHECK;
            end
            CHECK: begin
                state_next = last_cmd ? DONE : ISSUE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Registers only clear at the edge, so mask outputs for the whole reset cycle.
        if (reset) begin
            push_num       = 1'b0;
            shift_and_push = 1'b0;
            do_other_op    = 1'b0;
            done           = 1'b0;
            busy           = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_push_reg      <= 1'b0;
            first_reg        <= 1'b0;
            shift_reg        <= '0;
            op_reg           <= 3'd0;
            rem_reg          <= 2'd0;
            gap_cnt_reg      <= 8'd0;
            err_reg          <= 1'b0;
            resp_error_reg   <= 1'b0;
            resp_out_num_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        is_push_reg <= req_is_push;
                        first_reg   <= 1'b1;
                        shift_reg   <= req_is_push ? req_aligned : '0;
                        op_reg      <= req_is_push ? 3'd0 : req_op;
                        rem_reg     <= req_is_push ? 2'(req_bytes - 3'd1) : 2'd0;
                    end
                end
                ISSUE: begin
                    first_reg   <= 1'b0;
                    gap_cnt_reg <= 8'(CMD_GAP - 1);
                end
                WAIT: begin
                    if (gap_cnt_reg != 8'd0)
                        gap_cnt_reg <= gap_cnt_reg - 8'd1;
                end
                CHECK: begin
                    err_reg <= calc_error_bit;
                    if (!last_cmd) begin
                        shift_reg <= {shift_reg[23:0], 8'h0};
                        rem_reg   <= rem_reg - 2'd1;
                    end
                end
                DONE: begin
                    resp_error_reg   <= err_reg;
                    resp_out_num_reg <= calc_out_num;
                end
                default: ;
            endcase
        end
    end

    assign input_number  = reset ? 8'h00 : shift_reg[31:24];
    assign other_op_code = reset ? 3'd0  : op_reg;
    assign resp_error    = reset ? 1'b0  : resp_error_reg;
    assign resp_out_num  = reset ? '0    : resp_out_num_reg;

endmodule

// File: tb/tb_calc_command_issuer.sv
// Directed-vector bench for calc_command_issuer with CMD_GAP=48 (50-cycle command period).
module tb_calc_command_issuer;
    import calc_pkg::*;

    localparam int GAP    = 48;
    localparam int PERIOD = GAP + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_is_push;
    logic [31:0] req_value;
    logic [2:0]  req_op;
    logic        push_num, shift_and_push, do_other_op;
    logic [7:0]  input_number;
    logic [2:0]  other_op_code;
    logic        calc_error_bit;
    logic [31:0] calc_out_num;
    logic        busy, done, resp_error;
    logic [31:0] resp_out_num;

    always #5 clk = ~clk;

    calc_command_issuer #(.CMD_GAP(GAP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_push(req_is_push),
        .req_value(req_value), .req_op(req_op),
        .push_num(push_num), .shift_and_push(shift_and_push), .do_other_op(do_other_op),
        .input_number(input_number), .other_op_code(other_op_code),
        .calc_error_bit(calc_error_bit), .calc_out_num(calc_out_num),
        .busy(busy), .done(done), .resp_error(resp_error), .resp_out_num(resp_out_num)
    );

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic        is_push;
        logic [31:0] value;
        logic [2:0]  op;
        int          err_cmd;    // command index that sees calc_error_bit=1, -1 for none
        int          exp_cnt;
        logic [31:0] exp_bytes;  // expected bytes, first issued in [31:24]
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"},
            {29'd0, push_num, shift_and_push, do_other_op} | {busy, done, req_ready, resp_error, 28'd0},
            32'd0);
        chk({tag, "_input_number"}, {24'd0, input_number}, 32'd0);
        chk({tag, "_other_op_code"}, {29'd0, other_op_code}, 32'd0);
        chk({tag, "_resp_out_num"}, resp_out_num, 32'd0);
    endtask

    // Present a request at a negedge; the following posedge is the accept edge (cycle 0).
    task automatic send(input logic is_push, input logic [31:0] value, input logic [2:0] op);
        for (int t = 0; t < 20 && !req_ready; t++) @(negedge clk);
        chk("ready_before_send", {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_is_push = is_push;
        req_value   = value;
        req_op      = op;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int       nstr     = 0;
        int       done_cyc = -1;
        logic     excl_bad = 1'b0;
        logic     busy_bad = 1'b0;
        logic [2:0] strobes;
        logic [2:0] exp_type;
        calc_out_num = 32'hC0DE_0000 + i;
        send(v.is_push, v.value, v.op);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            strobes = {push_num, shift_and_push, do_other_op};
            if ($countones(strobes) > 1) excl_bad = 1'b1;
            if (!busy) busy_bad = 1'b1;
            if (strobes != 3'b000) begin
                if (nstr < v.exp_cnt) begin
                    chk("strobe_cycle", cyc, 1 + nstr * PERIOD);
                    exp_type = !v.is_push ? 3'b001 : (nstr == 0 ? 3'b100 : 3'b010);
                    chk("strobe_type", {29'd0, strobes}, {29'd0, exp_type});
                    if (v.is_push)
                        chk("input_number", {24'd0, input_number}, {24'd0, v.exp_bytes[31 - 8*nstr -: 8]});
                    else
                        chk("other_op_code", {29'd0, other_op_code}, {29'd0, v.op});
                end
                if (nstr == v.err_cmd) calc_error_bit = 1'b1;
                nstr++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            // A request arriving while busy must be ignored.
            if (cyc == 10) begin
                req_valid = 1'b1; req_is_push = 1'b1; req_value = 32'hDEAD_BEEF;
            end
            if (cyc == 11) req_valid = 1'b0;
        end
        chk("strobe_count", nstr, v.exp_cnt);
        chk("done_cycle", done_cyc, v.exp_cnt * PERIOD + 1);
        chk("exclusive", {31'd0, excl_bad}, 32'd0);
        chk("busy_during", {31'd0, busy_bad}, 32'd0);
        @(negedge clk);
        calc_error_bit = 1'b0;
        chk("resp_error", {31'd0, resp_error}, {31'd0, v.exp_err});
        chk("resp_out_num", resp_out_num, 32'hC0DE_0000 + i);
        chk("ready_after", {31'd0, req_ready}, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        $display("vec %0d: push=%0b value=0x%08h op=%0d strobes=%0d done_cycle=%0d resp_error=%0b",
                 i, v.is_push, v.value, v.op, nstr, done_cyc, resp_error);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes_before, strobes_after, dones_after;

        vecs[0] = '{1'b1, 32'h0000_0005, 3'd0, -1, 1, 32'h0500_0000, 1'b0};
        vecs[1] = '{1'b1, 32'h1234_5678, 3'd0, -1, 4, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 3'd0, -1, 4, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, DIV,   0, 1, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_ABCD, 3'd0,  0, 1, 32'hAB00_0000, 1'b1};
        vecs[5] = '{1'b1, 32'h0001_2345, 3'd0, -1, 3, 32'h0123_4500, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0000, SWAP, -1, 1, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0000, 3'd0, -1, 1, 32'h0000_0000, 1'b0};
        vecs[8] = '{1'b1, 32'h00AB_CDEF, 3'd0,  1, 2, 32'hABCD_0000, 1'b1};

        reset          = 1'b1;
        req_valid      = 1'b0;
        req_is_push    = 1'b0;
        req_value      = '0;
        req_op         = '0;
        calc_error_bit = 1'b0;
        calc_out_num   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("init_reset");
        reset = 1'b0;
        @(negedge clk);
        chk("init_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset in cycle 70 of a 4-byte push aborts the sequence.
        strobes_before = 0;
        strobes_after  = 0;
        dones_after    = 0;
        calc_out_num   = 32'h5555_AAAA;
        send(1'b1, 32'h1234_5678, 3'd0);
        for (int cyc = 1; cyc <= 220; cyc++) begin
            @(negedge clk);
            if (push_num | shift_and_push | do_other_op) begin
                if (cyc <= 70) strobes_before++;
                else strobes_after++;
            end
            if (done && cyc > 70) dones_after++;
            if (cyc == 51)
                chk("rst_pre_strobe", {24'd0, input_number}, 32'h34);
            if (cyc == 71) check_reset_outputs("mid_reset");
            if (cyc == 74) chk("rst_ready_release", {31'd0, req_ready}, 32'd1);
            if (cyc == 70) reset = 1'b1;
            if (cyc == 73) reset = 1'b0;
        end
        chk("rst_strobes_before", strobes_before, 2);
        chk("rst_strobes_after", strobes_after, 0);
        chk("rst_no_done", dones_after, 0);
        $display("reset abort: strobes before=%0d after=%0d dones=%0d", strobes_before, strobes_after, dones_after);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
